// File: rtl/oc8051_tmr01_if.sv
// SFR access bus between the oc8051 core and timer/counter 0/1.
interface oc8051_tmr01_if;
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       wr;
  logic       wr_bit;

  modport master (output wr_addr, rd_addr, data_in, wr, wr_bit, input data_out);
  modport slave  (input wr_addr, rd_addr, data_in, wr, wr_bit, output data_out);
endinterface

// File: rtl/oc8051_tmr01.sv
// oc8051 timer/counter 0 and 1 (TMOD, TL0/TH0, TL1/TH1) with tf0/tf1 overflow pulses.
// Define OC8051_TMR_GATE_EN to honour the TMOD GATE bits (run gated by int0/int1).
module oc8051_tmr01 #(
  parameter int unsigned CLK_DIV = 12
) (
  input  logic          clk,
  input  logic          rst,
  oc8051_tmr01_if.slave sfr,
  input  logic          tr0,
  input  logic          tr1,
  input  logic          t0,
  input  logic          t1,
  input  logic          int0,
  input  logic          int1,
  output logic          tf0,
  output logic          tf1
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  localparam logic [7:0] A_TMOD = 8'h89;
  localparam logic [7:0] A_TL0  = 8'h8A;
  localparam logic [7:0] A_TL1  = 8'h8B;
  localparam logic [7:0] A_TH0  = 8'h8C;
  localparam logic [7:0] A_TH1  = 8'h8D;

  typedef enum logic [1:0] {
    MODE13    = 2'd0,
    MODE16    = 2'd1,
    MODE8R    = 2'd2,
    MODESPLIT = 2'd3
  } tmode_e;

  logic [7:0]    r_tmod, r_tl0, r_th0, r_tl1, r_th1;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_t0_sync, r_t1_sync, r_int0_sync, r_int1_sync;
  logic          r_t0_d, r_t1_d;

  logic          w_tick, w_t0_fall, w_t1_fall;
  logic          w_wr_byte, w_wr_tmod, w_wr_tl0, w_wr_th0, w_wr_tl1, w_wr_th1;
  tmode_e        w_mode0, w_mode1;
  logic          w_gate0, w_gate1, w_run0, w_run1, w_inc0, w_inc1, w_th0_tick;
  logic [16:0]   w_step0, w_step1;
  logic [7:0]    w_tl0_nxt, w_th0_nxt, w_tl1_nxt, w_th1_nxt;
  logic          w_ovf0, w_ovf1, w_ovf_th0, w_tf1_nxt;
  logic [7:0]    w_rd_val, w_dout_nxt;
  logic          w_rd_mapped;

  // One increment of a TL/TH pair; returns {overflow, th, tl}. MODESPLIT covers the TL half only.
  function automatic logic [16:0] f_step(input tmode_e mode, input logic [7:0] tl,
                                         input logic [7:0] th);
    logic [12:0] c13;
    logic [15:0] c16;
    c13 = {th, tl[4:0]} + 13'd1;
    c16 = {th, tl} + 16'd1;
    case (mode)
      MODE13:  f_step = {&{th, tl[4:0]}, c13[12:5], tl[7:5], c13[4:0]};
      MODE16:  f_step = {&{th, tl}, c16};
      MODE8R:  f_step = (&tl) ? {1'b1, th, th} : {1'b0, th, tl + 8'd1};
      default: f_step = {&tl, th, tl + 8'd1};
    endcase
  endfunction

  always_comb begin
    w_tick    = (r_presc == PW'(CLK_DIV - 1));
    w_t0_fall = r_t0_d & ~r_t0_sync[1];
    w_t1_fall = r_t1_d & ~r_t1_sync[1];

    w_wr_byte = sfr.wr & ~sfr.wr_bit;
    w_wr_tmod = w_wr_byte && (sfr.wr_addr == A_TMOD);
    w_wr_tl0  = w_wr_byte && (sfr.wr_addr == A_TL0);
    w_wr_th0  = w_wr_byte && (sfr.wr_addr == A_TH0);
    w_wr_tl1  = w_wr_byte && (sfr.wr_addr == A_TL1);
    w_wr_th1  = w_wr_byte && (sfr.wr_addr == A_TH1);

    w_mode0 = tmode_e'(r_tmod[1:0]);
    w_mode1 = tmode_e'(r_tmod[5:4]);
`ifdef OC8051_TMR_GATE_EN
    w_gate0 = r_tmod[3];
    w_gate1 = r_tmod[7];
`else
    w_gate0 = 1'b0;
    w_gate1 = 1'b0;
`endif
    w_run0 = tr0 & (~w_gate0 | r_int0_sync[1]);
    w_run1 = tr1 & (~w_gate1 | r_int1_sync[1]);
    w_inc0 = (r_tmod[2] ? w_t0_fall : w_tick) & w_run0;
    w_inc1 = (r_tmod[6] ? w_t1_fall : w_tick) & w_run1;
    w_th0_tick = w_tick & tr1;

    w_step0 = f_step(w_mode0, r_tl0, r_th0);
    w_step1 = f_step(w_mode1, r_tl1, r_th1);
  end

  always_comb begin
    w_tl0_nxt = r_tl0;
    w_th0_nxt = r_th0;
    w_ovf0    = 1'b0;
    w_ovf_th0 = 1'b0;
    if (w_inc0) {w_ovf0, w_th0_nxt, w_tl0_nxt} = w_step0;
    // In split mode TH0 is its own 8-bit timer borrowing timer1's run bit.
    if (w_mode0 == MODESPLIT) begin
      w_th0_nxt = w_th0_tick ? r_th0 + 8'd1 : r_th0;
      w_ovf_th0 = w_th0_tick & (&r_th0);
    end
    if (w_wr_tl0 | w_wr_th0) begin
      w_tl0_nxt = w_wr_tl0 ? sfr.data_in : r_tl0;
      w_th0_nxt = w_wr_th0 ? sfr.data_in : r_th0;
      w_ovf0    = 1'b0;
      w_ovf_th0 = 1'b0;
    end

    w_tl1_nxt = r_tl1;
    w_th1_nxt = r_th1;
    w_ovf1    = 1'b0;
    if (w_inc1 && (w_mode1 != MODESPLIT)) {w_ovf1, w_th1_nxt, w_tl1_nxt} = w_step1;
    if (w_wr_tl1 | w_wr_th1) begin
      w_tl1_nxt = w_wr_tl1 ? sfr.data_in : r_tl1;
      w_th1_nxt = w_wr_th1 ? sfr.data_in : r_th1;
      w_ovf1    = 1'b0;
    end

    w_tf1_nxt = (w_mode0 == MODESPLIT) ? w_ovf_th0 : w_ovf1;
  end

  always_comb begin
    w_rd_val    = '0;
    w_rd_mapped = 1'b1;
    case (sfr.rd_addr)
      A_TMOD:  w_rd_val = r_tmod;
      A_TL0:   w_rd_val = r_tl0;
      A_TL1:   w_rd_val = r_tl1;
      A_TH0:   w_rd_val = r_th0;
      A_TH1:   w_rd_val = r_th1;
      default: w_rd_mapped = 1'b0;
    endcase
    w_dout_nxt = (w_wr_byte && w_rd_mapped && (sfr.wr_addr == sfr.rd_addr)) ? sfr.data_in
                                                                            : w_rd_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmod       <= '0;
      r_tl0        <= '0;
      r_th0        <= '0;
      r_tl1        <= '0;
      r_th1        <= '0;
      r_presc      <= '0;
      r_t0_sync    <= '1;
      r_t1_sync    <= '1;
      r_int0_sync  <= '1;
      r_int1_sync  <= '1;
      r_t0_d       <= 1'b1;
      r_t1_d       <= 1'b1;
      tf0          <= 1'b0;
      tf1          <= 1'b0;
      sfr.data_out <= '0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + PW'(1);
      r_t0_sync    <= {r_t0_sync[0], t0};
      r_t1_sync    <= {r_t1_sync[0], t1};
      r_int0_sync  <= {r_int0_sync[0], int0};
      r_int1_sync  <= {r_int1_sync[0], int1};
      r_t0_d       <= r_t0_sync[1];
      r_t1_d       <= r_t1_sync[1];
      if (w_wr_tmod) r_tmod <= sfr.data_in;
      r_tl0        <= w_tl0_nxt;
      r_th0        <= w_th0_nxt;
      r_tl1        <= w_tl1_nxt;
      r_th1        <= w_th1_nxt;
      tf0          <= w_ovf0;
      tf1          <= w_tf1_nxt;
      sfr.data_out <= w_dout_nxt;
    end
  end

endmodule

// File: tb/tb_oc8051_tmr01.sv
// Randomised bench for oc8051_tmr01 against a cycle-level arithmetic model of the timer rules.
module tb_oc8051_tmr01;
  localparam int unsigned DIV = 12;

  logic clk = 1'b0;
  logic rst, tr0, tr1, t0, t1, int0, int1, tf0, tf1;
  oc8051_tmr01_if sfr ();

  always #5 clk = ~clk;

  oc8051_tmr01 #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .sfr(sfr), .tr0(tr0), .tr1(tr1), .t0(t0), .t1(t1),
    .int0(int0), .int1(int1), .tf0(tf0), .tf1(tf1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference state: register contents as integers plus pin pipeline history.
  int m_tmod, m_presc, m_dout;
  int m_tl[2], m_th[2];
  bit m_tf0, m_tf1;
  bit m_tp[2][3];
  bit m_ip[2][2];

  function automatic int reg_val(input int a);
    case (a)
      'h89: return m_tmod;
      'h8A: return m_tl[0];
      'h8B: return m_tl[1];
      'h8C: return m_th[0];
      'h8D: return m_th[1];
      default: return 0;
    endcase
  endfunction

  task automatic pair_step(input int mode, input int tl, input int th,
                           output int ntl, output int nth, output bit ovf);
    int cnt;
    ovf = 0; ntl = tl; nth = th;
    case (mode)
      0: begin
        cnt = th * 32 + tl % 32 + 1;
        if (cnt == 8192) begin cnt = 0; ovf = 1; end
        nth = cnt / 32;
        ntl = (tl / 32) * 32 + cnt % 32;
      end
      1: begin
        cnt = th * 256 + tl + 1;
        if (cnt == 65536) begin cnt = 0; ovf = 1; end
        nth = cnt / 256;
        ntl = cnt % 256;
      end
      2: begin
        if (tl == 255) begin ntl = th; ovf = 1; end
        else ntl = tl + 1;
      end
      default: begin
        ntl = (tl + 1) % 256;
        ovf = (tl == 255);
      end
    endcase
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare #1 after the edge.
  task automatic step();
    int ntl[2], nth[2], mode[2], ntmod, ndout, npresc, wa, ra, nib;
    bit ovf[2], inc[2], tr[2], pin_t[2], pin_i[2];
    bit tick, wrb, ovf_th0, gate, ev, ntf0, ntf1, r;
    r = rst;
    tr[0] = tr0; tr[1] = tr1; pin_t[0] = t0; pin_t[1] = t1; pin_i[0] = int0; pin_i[1] = int1;
    wa = sfr.wr_addr; ra = sfr.rd_addr;
    wrb = sfr.wr && !sfr.wr_bit;
    tick = (m_presc == DIV - 1);
    ovf_th0 = 0;
    for (int unsigned x = 0; x < 2; x++) begin
      nib = (m_tmod >> (4 * x)) & 15;
      mode[x] = nib & 3;
`ifdef OC8051_TMR_GATE_EN
      gate = (nib >> 3) & 1;
`else
      gate = 0;
`endif
      ev = (nib & 4) ? (m_tp[x][2] && !m_tp[x][1]) : tick;
      inc[x] = ev && tr[x] && (!gate || m_ip[x][1]);
      ntl[x] = m_tl[x]; nth[x] = m_th[x]; ovf[x] = 0;
    end
    if (inc[0]) pair_step(mode[0], m_tl[0], m_th[0], ntl[0], nth[0], ovf[0]);
    if (mode[0] == 3 && tick && tr[1]) begin
      nth[0] = (m_th[0] + 1) % 256;
      ovf_th0 = (m_th[0] == 255);
    end
    if (inc[1] && mode[1] != 3) pair_step(mode[1], m_tl[1], m_th[1], ntl[1], nth[1], ovf[1]);
    ntmod = m_tmod;
    if (wrb) begin
      if (wa == 'h8A || wa == 'h8C) begin
        ntl[0] = m_tl[0]; nth[0] = m_th[0]; ovf[0] = 0; ovf_th0 = 0;
      end
      if (wa == 'h8B || wa == 'h8D) begin
        ntl[1] = m_tl[1]; nth[1] = m_th[1]; ovf[1] = 0;
      end
      case (wa)
        'h89: ntmod  = sfr.data_in;
        'h8A: ntl[0] = sfr.data_in;
        'h8B: ntl[1] = sfr.data_in;
        'h8C: nth[0] = sfr.data_in;
        'h8D: nth[1] = sfr.data_in;
        default: ;
      endcase
    end
    ntf0 = ovf[0];
    ntf1 = (mode[0] == 3) ? ovf_th0 : ovf[1];
    ndout = (wrb && wa == ra && ra >= 'h89 && ra <= 'h8D) ? int'(sfr.data_in) : reg_val(ra);
    npresc = tick ? 0 : m_presc + 1;

    @(posedge clk);
    if (r) begin
      m_tmod = 0; m_tl = '{0, 0}; m_th = '{0, 0}; m_presc = 0; m_dout = 0;
      m_tf0 = 0; m_tf1 = 0;
      for (int unsigned x = 0; x < 2; x++) begin
        m_tp[x] = '{1, 1, 1}; m_ip[x] = '{1, 1};
      end
    end else begin
      m_tmod = ntmod; m_tl = ntl; m_th = nth; m_presc = npresc; m_dout = ndout;
      m_tf0 = ntf0; m_tf1 = ntf1;
      for (int unsigned x = 0; x < 2; x++) begin
        m_tp[x][2] = m_tp[x][1]; m_tp[x][1] = m_tp[x][0]; m_tp[x][0] = pin_t[x];
        m_ip[x][1] = m_ip[x][0]; m_ip[x][0] = pin_i[x];
      end
    end
    #1;
    check("tf0", 16'(tf0), 16'(m_tf0));
    check("tf1", 16'(tf1), 16'(m_tf1));
    check("data_out", 16'(sfr.data_out), 16'(m_dout));
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    sfr.wr = 1'b1; sfr.wr_bit = 1'b0; sfr.wr_addr = a; sfr.data_in = d;
    step();
    sfr.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
    sfr.rd_addr = a;
    step();
    v = sfr.data_out;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Steps until the named pulse appears; an expired budget reports as a failed check.
  task automatic wait_pulse(input string tag, input bit on_tf1, input int unsigned budget);
    bit seen = 0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      step();
      seen = on_tf1 ? tf1 : tf0;
    end
    check(tag, 16'(seen), 16'd1);
  endtask

  function automatic logic [7:0] pick_data();
    case ($urandom_range(0, 5))
      0: return 8'hFF;
      1: return 8'hFE;
      2: return 8'h1F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] v;
    int unsigned cnt;
    bit seen;
    rst = 1'b1; tr0 = 0; tr1 = 0; t0 = 1; t1 = 1; int0 = 1; int1 = 1;
    sfr.wr = 0; sfr.wr_bit = 0; sfr.wr_addr = 8'h00; sfr.rd_addr = 8'h00; sfr.data_in = 8'h00;
    step();
    rst = 1'b0;
    check("rst_tf0", 16'(tf0), 16'd0);
    check("rst_tf1", 16'(tf1), 16'd0);
    for (int unsigned a = 8'h89; a <= 8'h8D; a++) begin
      rd_reg(8'(a), v);
      check("rst_read", 16'(v), 16'h00);
    end
    idle(15);
    rd_reg(8'h8A, v);
    check("tl0_idle", 16'(v), 16'h00);

    // Mode 1 rollover from 0xFFFE
    wr_reg(8'h89, 8'h01); wr_reg(8'h8C, 8'hFF); wr_reg(8'h8A, 8'hFE);
    tr0 = 1;
    wait_pulse("m1_tf0", 0, 40);
    rd_reg(8'h8A, v); check("m1_tl0", 16'(v), 16'h00);
    rd_reg(8'h8C, v); check("m1_th0", 16'(v), 16'h00);
    tr0 = 0;

    // Mode 2 auto-reload: one tf1 every three ticks
    wr_reg(8'h89, 8'h20); wr_reg(8'h8D, 8'hFD); wr_reg(8'h8B, 8'hFD);
    tr1 = 1; cnt = 0;
    for (int unsigned i = 0; i < 9 * DIV + 1; i++) begin
      step();
      cnt += tf1;
    end
    check("m2_tf1_cnt", 16'(cnt), 16'd3);
    tr1 = 0;

    // Counter mode 0 on t0 falling edges
    wr_reg(8'h89, 8'h04); wr_reg(8'h8A, 8'h00); wr_reg(8'h8C, 8'h00);
    tr0 = 1;
    for (int unsigned e = 0; e < 5; e++) begin
      t0 = 0; idle(4); t0 = 1; idle(4);
    end
    idle(4);
    rd_reg(8'h8A, v); check("ctr_tl0", 16'(v), 16'h05);
    wr_reg(8'h8C, 8'hFF); wr_reg(8'h8A, 8'h1F);
    t0 = 0;
    wait_pulse("ctr_tf0", 0, 10);
    t0 = 1;
    rd_reg(8'h8C, v); check("ctr_th0", 16'(v), 16'h00);
    rd_reg(8'h8A, v); check("ctr_tl0_wrap", 16'(v), 16'h00);
    tr0 = 0;

    // Mode 3: TH0 on tick & tr1 drives tf1, TL0 frozen with tr0=0
    wr_reg(8'h89, 8'h03); wr_reg(8'h8A, 8'h55); wr_reg(8'h8C, 8'hFE);
    tr1 = 1;
    wait_pulse("m3_tf1", 1, 40);
    rd_reg(8'h8A, v); check("m3_tl0", 16'(v), 16'h55);
    tr1 = 0;

    // Write collision at the overflowing tick
    wr_reg(8'h89, 8'h01); wr_reg(8'h8C, 8'hFF); wr_reg(8'h8A, 8'hFF);
    tr0 = 1;
    for (int unsigned i = 0; i < DIV && m_presc != DIV - 1; i++) step();
    check("coll_phase", 16'(m_presc), 16'(DIV - 1));
    wr_reg(8'h8A, 8'h10);
    seen = 0;
    for (int unsigned i = 0; i < 3; i++) begin step(); seen |= tf0; end
    check("coll_no_tf0", 16'(seen), 16'd0);
    rd_reg(8'h8A, v); check("coll_tl0", 16'(v), 16'h10);
    rd_reg(8'h8C, v); check("coll_th0", 16'(v), 16'hFF);
    tr0 = 0;

    // GATE: int0 low holds timer0 only when gating is built in
    wr_reg(8'h89, 8'h09); wr_reg(8'h8A, 8'h00); wr_reg(8'h8C, 8'h00);
    int0 = 0; tr0 = 1;
    idle(40);
    rd_reg(8'h8A, v);
`ifdef OC8051_TMR_GATE_EN
    check("gate_hold", 16'(v), 16'h00);
`else
    check("gate_ignored", 16'(v != 0), 16'd1);
`endif
    int0 = 1; wr_reg(8'h8A, 8'h00);
    idle(40);
    rd_reg(8'h8A, v);
    check("gate_open", 16'(v != 0), 16'd1);
    tr0 = 0;

    // Random traffic against the model
    for (int unsigned i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      sfr.wr = ($urandom_range(0, 7) == 0);
      sfr.wr_bit = ($urandom_range(0, 5) == 0);
      sfr.wr_addr = 8'($urandom_range(8'h88, 8'h8E));
      if (sfr.wr_addr == 8'h89 && $urandom_range(0, 2) != 0) sfr.wr = 0;
      sfr.data_in = pick_data();
      sfr.rd_addr = 8'($urandom_range(8'h87, 8'h8E));
      if ($urandom_range(0, 19) == 0) tr0 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) tr1 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) t0 = ~t0;
      if ($urandom_range(0, 4) == 0) t1 = ~t1;
      if ($urandom_range(0, 29) == 0) int0 = ~int0;
      if ($urandom_range(0, 29) == 0) int1 = ~int1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
